// File: rtl/alu_seq_pkg.sv
// Shared encodings for the ALU sequencer: request opcodes, ALU function
// codes and the sequencer state set.
package alu_seq_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_BEQ = 3'b100;
  localparam logic [2:0] OP_BNE = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_ILL = 3'b111;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0011;
  localparam logic [3:0] ALU_NOP = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MUL  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Branch compares are subtractions; the sequencer derives taken from zero.
  function automatic logic [3:0] op_to_code(input logic [2:0] op);
    logic [3:0] code;
    case (op)
      OP_AND:                 code = ALU_AND;
      OP_OR:                  code = ALU_OR;
      OP_ADD:                 code = ALU_ADD;
      OP_SUB, OP_BEQ, OP_BNE: code = ALU_SUB;
      default:                code = ALU_NOP;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/alu_seq_alu.sv
// Combinational 64-bit ALU that sits beside the sequencer as a peer.
// Overflow is signed overflow for ADD/SUB; unknown codes yield zero.
module alu_seq_alu
  import alu_seq_pkg::*;
(
  input  logic [3:0]  alu_code,
  input  logic [63:0] alu_src_1,
  input  logic [63:0] alu_src_2,
  output logic [63:0] alu_result,
  output logic        alu_overflow,
  output logic        alu_zero
);

  logic [63:0] sum;
  logic [63:0] diff;

  assign sum  = alu_src_1 + alu_src_2;
  assign diff = alu_src_1 - alu_src_2;

  always_comb begin
    alu_result   = '0;
    alu_overflow = 1'b0;
    case (alu_code)
      ALU_AND: alu_result = alu_src_1 & alu_src_2;
      ALU_OR:  alu_result = alu_src_1 | alu_src_2;
      ALU_ADD: begin
        alu_result   = sum;
        alu_overflow = (alu_src_1[63] == alu_src_2[63]) && (sum[63] != alu_src_1[63]);
      end
      ALU_SUB: begin
        alu_result   = diff;
        alu_overflow = (alu_src_1[63] != alu_src_2[63]) && (diff[63] != alu_src_1[63]);
      end
      default: begin
        alu_result   = '0;
        alu_overflow = 1'b0;
      end
    endcase
  end

  assign alu_zero = (alu_result == 64'd0);

endmodule

// File: rtl/alu_sequencer.sv
// Sequences single-cycle ALU operations and a 64-iteration shift-add multiply
// through an external combinational ALU, returning one response per request.
module alu_sequencer
  import alu_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_op,
  input  logic [63:0] in_a,
  input  logic [63:0] in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_result,
  output logic        out_overflow,
  output logic        out_zero,
  output logic        out_taken,
  output logic [63:0] alu_src_1,
  output logic [63:0] alu_src_2,
  output logic [3:0]  alu_code,
  input  logic [63:0] alu_result,
  input  logic        alu_overflow,
  input  logic        alu_zero,
  output logic [1:0]  dbg_state
);

  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_EXEC = ST_EXEC;
  localparam logic [1:0] S_MUL  = ST_MUL;
  localparam logic [1:0] S_DONE = ST_DONE;

  logic [1:0]  state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [63:0] opa_q, opa_d;     // operand a; multiplicand during MUL
  logic [63:0] opb_q, opb_d;     // operand b; multiplier during MUL
  logic [63:0] acc_q, acc_d;
  logic [6:0]  count_q, count_d;
  logic [63:0] res_q, res_d;
  logic        ovf_q, ovf_d;
  logic        zero_q, zero_d;
  logic        taken_q, taken_d;

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // in_ready is high only in IDLE; out_valid is high only in DONE and the
  // response registers hold still until out_ready is seen at an edge.
  assign in_ready     = (state_q == S_IDLE);
  assign out_valid    = (state_q == S_DONE);
  assign out_result   = res_q;
  assign out_overflow = ovf_q;
  assign out_zero     = zero_q;
  assign out_taken    = taken_q;
  assign dbg_state    = state_q;

  always_comb begin
    alu_code  = ALU_NOP;
    alu_src_1 = '0;
    alu_src_2 = '0;
    if (state_q == S_EXEC) begin
      alu_code  = op_to_code(op_q);
      alu_src_1 = opa_q;
      alu_src_2 = opb_q;
    end else if (state_q == S_MUL) begin
      alu_code  = ALU_ADD;
      alu_src_1 = acc_q;
      alu_src_2 = opb_q[0] ? opa_q : 64'd0;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    acc_d   = acc_q;
    count_d = count_q;
    res_d   = res_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    taken_d = taken_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          op_d  = in_op;
          opa_d = in_a;
          opb_d = in_b;
          if (in_op == OP_MUL) begin
            acc_d   = '0;
            count_d = 7'd64;
            state_d = S_MUL;
          end else begin
            state_d = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        res_d   = alu_result;
        ovf_d   = alu_overflow;
        zero_d  = alu_zero;
        taken_d = (op_q == OP_BEQ) ? alu_zero :
                  (op_q == OP_BNE) ? !alu_zero : 1'b0;
        state_d = S_DONE;
      end
      S_MUL: begin
        acc_d   = alu_result;
        opa_d   = {opa_q[62:0], 1'b0};
        opb_d   = {1'b0, opb_q[63:1]};
        count_d = count_q - 7'd1;
        // Always runs all 64 iterations so latency is data-independent.
        if (count_q == 7'd1) begin
          res_d   = alu_result;
          ovf_d   = 1'b0;
          zero_d  = (alu_result == 64'd0);
          taken_d = 1'b0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      acc_q   <= '0;
      count_q <= '0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      taken_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
      taken_q <= taken_d;
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer wired to its peer ALU: directed corner cases then
// random requests, each compared against an arithmetic reference model.
module tb_alu_sequencer;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [63:0] in_a;
  logic [63:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_result;
  logic        out_overflow;
  logic        out_zero;
  logic        out_taken;
  logic [63:0] alu_src_1;
  logic [63:0] alu_src_2;
  logic [3:0]  alu_code;
  logic [63:0] alu_result;
  logic        alu_overflow;
  logic        alu_zero;
  logic [1:0]  dbg_state;

  int n_pass  = 0;
  int n_total = 0;
  logic [66:0] exp_q[$];

  alu_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_op        (in_op),
    .in_a         (in_a),
    .in_b         (in_b),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_overflow (out_overflow),
    .out_zero     (out_zero),
    .out_taken    (out_taken),
    .alu_src_1    (alu_src_1),
    .alu_src_2    (alu_src_2),
    .alu_code     (alu_code),
    .alu_result   (alu_result),
    .alu_overflow (alu_overflow),
    .alu_zero     (alu_zero),
    .dbg_state    (dbg_state)
  );

  alu_seq_alu u_alu (
    .alu_code     (alu_code),
    .alu_src_1    (alu_src_1),
    .alu_src_2    (alu_src_2),
    .alu_result   (alu_result),
    .alu_overflow (alu_overflow),
    .alu_zero     (alu_zero)
  );

  // Clock and time limit
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, checks %0d/%0d", n_pass, n_total);
    $fatal(1, "time limit");
  end

  // Reference model: {result, overflow, zero, taken} from plain arithmetic.
  function automatic logic [66:0] ref_model(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    logic [63:0] r;
    logic        ov;
    logic        tk;
    r  = '0;
    ov = 1'b0;
    tk = 1'b0;
    case (op)
      3'd0: r = a & b;
      3'd1: r = a | b;
      3'd2: begin
        r  = a + b;
        ov = ($signed(a) >= 0) == ($signed(b) >= 0) && (($signed(r) >= 0) != ($signed(a) >= 0));
      end
      3'd3, 3'd4, 3'd5: begin
        r  = a - b;
        ov = (($signed(a) >= 0) != ($signed(b) >= 0)) && (($signed(r) >= 0) != ($signed(a) >= 0));
        tk = (op == 3'd4) ? (a == b) : (op == 3'd5) ? (a != b) : 1'b0;
      end
      3'd6: r = a * b;
      default: r = '0;
    endcase
    return {r, ov, (r == 64'd0), tk};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic apply_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Driver: issue one request, verify latency and response, hold off out_ready
  // for `hold` cycles while poking junk requests, then release.
  task automatic run_op(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                        input int hold, output logic [63:0] res_o);
    logic [66:0] exp;
    logic [63:0] snap_r;
    logic [2:0]  snap_f;
    int lat;
    int want_lat;
    exp_q.push_back(ref_model(op, a, b));
    want_lat = (op == 3'b110) ? 64 : 1;
    chk("in_ready_before_accept", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    @(posedge clk);
    #1;
    in_a  = {$urandom, $urandom};
    in_b  = {$urandom, $urandom};
    in_op = 3'($urandom_range(0, 7));
    lat = 0;
    do begin
      in_valid = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      lat++;
    end while (!out_valid && lat < 200);
    in_valid = 1'b0;
    chk("latency", 64'(lat), 64'(want_lat));
    exp = exp_q.pop_front();
    res_o = out_result;
    if (!out_valid) begin
      apply_reset();
      return;
    end
    chk("result", out_result, exp[66:3]);
    chk("overflow", 64'(out_overflow), 64'(exp[2]));
    chk("zero", 64'(out_zero), 64'(exp[1]));
    chk("taken", 64'(out_taken), 64'(exp[0]));
    snap_r = out_result;
    snap_f = {out_overflow, out_zero, out_taken};
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      in_op    = 3'($urandom_range(0, 7));
      in_a     = {$urandom, $urandom};
      @(posedge clk);
      #1;
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_result_stable", out_result, snap_r);
      chk("bp_flags_stable", 64'({out_overflow, out_zero, out_taken}), 64'(snap_f));
      chk("bp_in_ready", 64'(in_ready), 64'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("release_out_valid", 64'(out_valid), 64'd0);
    chk("release_in_ready", 64'(in_ready), 64'd1);
    chk("idle_alu_code", 64'(alu_code), 64'hF);
    chk("idle_alu_srcs", alu_src_1 | alu_src_2, 64'd0);
  endtask

  // Directed steps followed by random traffic, then the report.
  initial begin
    logic [63:0] r;
    logic [2:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    in_op = '0;
    in_a  = '0;
    in_b  = '0;
    apply_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_result", out_result, 64'd0);
    chk("reset_flags", 64'({out_overflow, out_zero, out_taken}), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_op(3'b010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 0, r);
    chk("add_max_plus_one", r, 64'h8000_0000_0000_0000);
    run_op(3'b100, 64'd5, 64'd5, 0, r);
    run_op(3'b101, 64'd5, 64'd5, 0, r);
    run_op(3'b110, 64'd3, 64'd7, 0, r);
    chk("mul_3x7", r, 64'd21);
    run_op(3'b110, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1, r);
    chk("mul_neg1x2", r, 64'hFFFF_FFFF_FFFF_FFFE);
    run_op(3'b010, 64'h1234, 64'h4321, 10, r);
    run_op(3'b111, 64'hDEAD, 64'hBEEF, 0, r);
    chk("illegal_result", r, 64'd0);
    run_op(3'b011, 64'h8000_0000_0000_0000, 64'd1, 0, r);

    // Reset in the middle of a multiply abandons it.
    in_valid = 1'b1;
    in_op    = 3'b110;
    in_a     = 64'd3;
    in_b     = 64'd7;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (29) @(posedge clk);
    #1;
    chk("mul_drive_code", 64'(alu_code), 64'h2);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("midmul_reset_valid", 64'(out_valid), 64'd0);
    chk("midmul_reset_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    chk("post_reset_valid", 64'(out_valid), 64'd0);
    run_op(3'b000, 64'hF0, 64'h3C, 0, r);
    chk("and_after_reset", r, 64'h30);

    for (int i = 0; i < 24; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0:       b = a;
        1:       b = 64'($urandom_range(0, 15));
        default: b = {$urandom, $urandom};
      endcase
      run_op(op, a, b, $urandom_range(0, 3), r);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL expose: clk  input  1  sole clock, all state updates on rising edge.
REQ-002 SHALL expose: rst_n  input  1  reset, synchronous, active-low.
REQ-003 SHALL expose: in_valid  input  1  request present.
REQ-004 SHALL expose: in_ready  output  1  sequencer can accept a request.
REQ-005 SHALL expose: in_op  input  3  000 AND, 001 OR, 010 ADD, 011 SUB, 100 BEQ, 101 BNE, 110 MUL, 111 illegal.
REQ-006 SHALL expose: in_a, in_b  input  64 each  signed operands.
REQ-007 SHALL expose: out_valid  output  1;  out_ready  input  1  response handshake.
REQ-008 SHALL expose: out_result  output  64;  out_overflow, out_zero, out_taken  output  1 each.
REQ-009 SHALL expose: alu_src_1, alu_src_2  output  64;  alu_code  output  4  drive side of the ALU interface.
REQ-010 SHALL expose: alu_result  input  64;  alu_overflow, alu_zero  input  1  ALU return side (combinational ALU).

Function
REQ-011 States: IDLE, EXEC, MUL, DONE; in_ready = (state==IDLE).
REQ-012 IDLE: on in_valid, latch in_op/in_a/in_b; next EXEC if op in {000..101,111}, MUL if op==110.
REQ-013 EXEC: alu_code/sources from latched op/operands; next edge captures alu_result/overflow/zero into out regs, state DONE.
REQ-014 Code map: AND->0000, OR->0001, ADD->0010, SUB/BEQ/BNE->0011, illegal->1111 (ALU yields result 0, zero=1, overflow=0).
REQ-015 out_taken: BEQ = alu_zero, BNE = !alu_zero, all other ops 0.
REQ-016 Single-cycle latency: accept edge E0, result captured E1, out_valid high from E1.
REQ-017 MUL: unsigned shift-add, low 64 bits; on entry acc=0, mcand=a, mplier=b, count=64.
REQ-018 Each MUL cycle: alu_code=0010, alu_src_1=acc, alu_src_2 = mplier[0] ? mcand : 0; on edge acc<=alu_result, mcand<<=1, mplier>>=1, count--.
REQ-019 MUL ends after exactly 64 MUL cycles (no early exit); out_valid from E64; out_result=acc, out_zero=(acc==0), out_overflow=0, out_taken=0.
REQ-020 DONE: out_valid=1, out regs stable; on out_ready go IDLE; no new accept same cycle (in_ready=0 in DONE).
REQ-021 out_valid SHALL not drop, nor out data change, until out_ready sampled high.
REQ-022 Outside EXEC/MUL: alu_code=1111, alu_src_1=alu_src_2=0.
REQ-023 in_valid outside IDLE SHALL be ignored; in_a/in_b changes after acceptance SHALL not affect the operation.
REQ-024 ALU overflow wraps silently; sequencer only reports it.

Reset
REQ-025 rst_n low at an edge: state IDLE, out_valid=0, out_result=0, out_overflow=0, out_zero=0, out_taken=0, count=0, acc=0.
REQ-026 Reset mid-EXEC/MUL/DONE SHALL abandon the operation with no response; in_ready=1 from the first edge after rst_n high.

Structure
REQ-027 Shared package alu_seq_pkg: in_op encodings, state enum, ALU code constants 0000/0001/0010/0011/1111.
REQ-028 No sub-module; the ALU stays an external peer, instantiated beside the sequencer by the parent and by the bench.

Verification
REQ-029 ADD a=0x7FFF_FFFF_FFFF_FFFF, b=1 -> one cycle after accept, result 0x8000_0000_0000_0000, overflow=1, zero=0.
REQ-030 BEQ a=b=5 -> result 0, zero=1, taken=1; BNE same operands -> taken=0.
REQ-031 MUL a=3, b=7 -> out_valid exactly 64 cycles after accept, result 21, overflow=0; MUL a=-1, b=2 -> 0xFFFF_FFFF_FFFF_FFFE.
REQ-032 Backpressure: out_ready held low 10 cycles after out_valid -> output stable, in_ready=0, new in_valid ignored.
REQ-033 rst_n low at MUL iteration 30 -> next cycle IDLE, out_valid=0; fresh AND 0xF0 & 0x3C -> 0x30.
REQ-034 Illegal op 111 -> result 0, zero=1, overflow=0, taken=0, single-cycle latency.
